// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared widths, PC operation encodings and sequencer states
package pc_seq_pkg;
   localparam int PC_W      = 12;
   localparam int OFF_W     = 8;
   localparam int STK_DEPTH = 8;

   typedef enum logic [3:0] {
      OP_INC  = 4'b0000,
      OP_BZ   = 4'b0100,
      OP_BNZ  = 4'b0101,
      OP_BC   = 4'b0110,
      OP_BNC  = 4'b0111,
      OP_JMP  = 4'b1000,
      OP_CALL = 4'b1001,
      OP_RET  = 4'b1010,
      OP_RETI = 4'b1011,
      OP_INT  = 4'b1100
   } pcoper_e;

   typedef enum logic {
      RUN       = 1'b0,
      IRQ_ENTRY = 1'b1
   } seq_state_e;
endpackage

// File: rtl/new_pc.sv
// new_pc: combinational next-address selection from the decoded PC operation
module new_pc #(
   parameter int PC_W  = pc_seq_pkg::PC_W,
   parameter int OFF_W = pc_seq_pkg::OFF_W
) (
   input  logic [PC_W-1:0]  pc_i,
   input  logic [3:0]       pcoper_i,
   input  logic             zero_i,
   input  logic             carry_i,
   input  logic [OFF_W-1:0] offset_i,
   input  logic [PC_W-1:0]  jump_i,
   input  logic [PC_W-1:0]  stk_i,
   input  logic [PC_W-1:0]  int_i,
   input  logic             int_sel_i,
   output logic [PC_W-1:0]  npc_o
);
   import pc_seq_pkg::*;

   logic [PC_W-1:0] w_inc;
   logic [PC_W-1:0] w_br;

   always_comb begin
      w_inc = pc_i + PC_W'(1);
      w_br  = pc_i + {{(PC_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};
      npc_o = w_inc;
      case (pcoper_i)
         OP_BZ:           npc_o = zero_i   ? w_br : w_inc;
         OP_BNZ:          npc_o = !zero_i  ? w_br : w_inc;
         OP_BC:           npc_o = carry_i  ? w_br : w_inc;
         OP_BNC:          npc_o = !carry_i ? w_br : w_inc;
         OP_JMP, OP_CALL: npc_o = jump_i;
         OP_RET, OP_RETI: npc_o = stk_i;
         default:         npc_o = w_inc;
      endcase
      if (int_sel_i) npc_o = int_i;
   end
endmodule

// File: rtl/return_stack.sv
// return_stack: DEPTH x W LIFO with a 0..DEPTH pointer; full pushes and empty pops are ignored
module return_stack #(
   parameter int W     = pc_seq_pkg::PC_W,
   parameter int DEPTH = pc_seq_pkg::STK_DEPTH
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] top_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW:0]   r_ptr;
   logic [AW-1:0] w_top_idx;

   assign full_o    = r_ptr == (AW+1)'(DEPTH);
   assign empty_o   = r_ptr == '0;
   assign w_top_idx = r_ptr[AW-1:0] - AW'(1);
   assign top_o     = r_mem[w_top_idx];

   always_ff @(posedge clk_i) begin
      if (rst_i) r_ptr <= '0;
      else if (push_i && !full_o) r_ptr <= r_ptr + (AW+1)'(1);
      else if (pop_i && !empty_o) r_ptr <= r_ptr - (AW+1)'(1);
   end

   // Contents need no reset: the pointer alone defines what is valid
   always_ff @(posedge clk_i) begin
      if (push_i && !full_o) r_mem[r_ptr[AW-1:0]] <= wdata_i;
   end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, interrupt-entry FSM, return-stack control and sticky stack flags
module pc_sequencer #(
   parameter int PC_W      = pc_seq_pkg::PC_W,
   parameter int OFF_W     = pc_seq_pkg::OFF_W,
   parameter int STK_DEPTH = pc_seq_pkg::STK_DEPTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [3:0]       pcoper_i,
   input  logic             zero_i,
   input  logic             carry_i,
   input  logic [OFF_W-1:0] offset_i,
   input  logic [PC_W-1:0]  jump_i,
   input  logic             stall_i,
   input  logic             irq_i,
   input  logic [PC_W-1:0]  irq_vec_i,
   input  logic             int_en_i,
   output logic [PC_W-1:0]  pc_o,
   output logic             irq_ack_o,
   output logic             in_isr_o,
   output logic             stk_ovf_o,
   output logic             stk_unf_o
);
   import pc_seq_pkg::*;

   seq_state_e      r_state;
   seq_state_e      w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_npc;
   logic [PC_W-1:0] w_top;
   logic [PC_W-1:0] w_stk;
   logic [PC_W-1:0] w_wdata;
   logic            r_in_isr;
   logic            r_ovf;
   logic            r_unf;
   logic            w_full;
   logic            w_empty;
   logic            w_entry;
   logic            w_irq_go;
   logic            w_exec;
   logic            w_push;
   logic            w_pop;
   logic            w_reti;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= RUN;
      else r_state <= w_state_nxt;
   end

   // Interrupt acceptance costs one bubble; the pending instruction's PC is what gets pushed
   always_comb begin
      w_entry     = r_state == IRQ_ENTRY;
      w_irq_go    = r_state == RUN && !stall_i && irq_i && int_en_i && !r_in_isr;
      w_exec      = r_state == RUN && !stall_i && !w_irq_go;
      w_state_nxt = w_irq_go ? IRQ_ENTRY : RUN;
      w_push      = w_entry || (w_exec && pcoper_i == OP_CALL);
      w_pop       = w_exec && (pcoper_i == OP_RET || pcoper_i == OP_RETI);
      w_reti      = w_exec && pcoper_i == OP_RETI;
      w_wdata     = w_entry ? r_pc : r_pc + PC_W'(1);
      w_stk       = w_empty ? '0 : w_top;
   end

   return_stack #(.W(PC_W), .DEPTH(STK_DEPTH)) u_stack (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .wdata_i (w_wdata),
      .top_o   (w_top),
      .full_o  (w_full),
      .empty_o (w_empty)
   );

   new_pc #(.PC_W(PC_W), .OFF_W(OFF_W)) u_new_pc (
      .pc_i      (r_pc),
      .pcoper_i  (pcoper_i),
      .zero_i    (zero_i),
      .carry_i   (carry_i),
      .offset_i  (offset_i),
      .jump_i    (jump_i),
      .stk_i     (w_stk),
      .int_i     (irq_vec_i),
      .int_sel_i (w_entry),
      .npc_o     (w_npc)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc     <= '0;
         r_in_isr <= 1'b0;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         if (w_entry || w_exec) r_pc <= w_npc;
         r_in_isr <= w_entry ? 1'b1 : w_reti ? 1'b0 : r_in_isr;
         r_ovf    <= r_ovf | (w_push & w_full);
         r_unf    <= r_unf | (w_pop & w_empty);
      end
   end

   assign pc_o      = r_pc;
   assign irq_ack_o = w_entry;
   assign in_isr_o  = r_in_isr;
   assign stk_ovf_o = r_ovf;
   assign stk_unf_o = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed and random stimulus against a queue-based reference model with a scoreboard
module tb_pc_sequencer;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  pcoper;
   logic        zero;
   logic        carry;
   logic [7:0]  offset;
   logic [11:0] jump;
   logic        stall;
   logic        irq;
   logic [11:0] vec;
   logic        int_en;
   logic [11:0] pc_o;
   logic        irq_ack_o;
   logic        in_isr_o;
   logic        stk_ovf_o;
   logic        stk_unf_o;

   typedef struct packed {
      logic [11:0] pc;
      logic        ack;
      logic        isr;
      logic        ovf;
      logic        unf;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   int   m_pc = 0;
   int   m_stk[$];
   bit   m_entry, m_isr, m_ovf, m_unf;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .pcoper_i  (pcoper),
      .zero_i    (zero),
      .carry_i   (carry),
      .offset_i  (offset),
      .jump_i    (jump),
      .stall_i   (stall),
      .irq_i     (irq),
      .irq_vec_i (vec),
      .int_en_i  (int_en),
      .pc_o      (pc_o),
      .irq_ack_o (irq_ack_o),
      .in_isr_o  (in_isr_o),
      .stk_ovf_o (stk_ovf_o),
      .stk_unf_o (stk_unf_o)
   );

   // Reference: advance the model by one clock using the current inputs, queue the expectation
   task automatic tick();
      exp_t e;
      if (rst) begin
         m_pc = 0; m_stk.delete(); m_entry = 0; m_isr = 0; m_ovf = 0; m_unf = 0;
      end else if (m_entry) begin
         if (m_stk.size() == DEPTH) m_ovf = 1; else m_stk.push_back(m_pc);
         m_pc = int'(vec); m_isr = 1; m_entry = 0;
      end else if (stall) begin
      end else if (irq && int_en && !m_isr) begin
         m_entry = 1;
      end else begin
         case (pcoper)
            4'b0100: m_pc = zero   ? m_pc + int'($signed(offset)) : m_pc + 1;
            4'b0101: m_pc = !zero  ? m_pc + int'($signed(offset)) : m_pc + 1;
            4'b0110: m_pc = carry  ? m_pc + int'($signed(offset)) : m_pc + 1;
            4'b0111: m_pc = !carry ? m_pc + int'($signed(offset)) : m_pc + 1;
            4'b1000: m_pc = int'(jump);
            4'b1001: begin
               if (m_stk.size() == DEPTH) m_ovf = 1; else m_stk.push_back((m_pc + 1) & 'hFFF);
               m_pc = int'(jump);
            end
            4'b1010, 4'b1011: begin
               if (m_stk.size() == 0) begin m_unf = 1; m_pc = 0; end
               else m_pc = m_stk.pop_back();
               if (pcoper == 4'b1011) m_isr = 0;
            end
            default: m_pc = m_pc + 1;
         endcase
      end
      m_pc = m_pc & 'hFFF;
      e.pc = m_pc[11:0]; e.ack = m_entry; e.isr = m_isr; e.ovf = m_ovf; e.unf = m_unf;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input logic [3:0] o, input logic [11:0] j = 12'h000, input logic [7:0] off = 8'h00);
      pcoper = o; jump = j; offset = off;
      tick();
   endtask

   task automatic chk(input string n, input logic [11:0] got, input logic [11:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cycle %0d got %h expected %h", n, cyc, got, want);
      end
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      cyc++;
      if (q.size() != 0) begin
         e = q.pop_front();
         chk("pc", pc_o, e.pc);
         chk("irq_ack", {11'd0, irq_ack_o}, {11'd0, e.ack});
         chk("in_isr", {11'd0, in_isr_o}, {11'd0, e.isr});
         chk("stk_ovf", {11'd0, stk_ovf_o}, {11'd0, e.ovf});
         chk("stk_unf", {11'd0, stk_unf_o}, {11'd0, e.unf});
      end
   end

   initial begin
      rst = 1; pcoper = 0; zero = 0; carry = 0; offset = 0; jump = 0;
      stall = 0; irq = 0; vec = 0; int_en = 0;
      tick();
      rst = 0;
      repeat (5) run(4'b0000);
      rst = 1; tick(); rst = 0;
      run(4'b1000, 12'h010); zero = 1; run(4'b0100, 12'h000, 8'hF8);
      run(4'b1000, 12'h010); zero = 0; run(4'b0100, 12'h000, 8'hF8);
      run(4'b1000, 12'hFFF); run(4'b0000);
      run(4'b1000, 12'h020); run(4'b1001, 12'h100); run(4'b1010);
      for (int i = 0; i < 9; i++) run(4'b1001, 12'(12'h300 + i * 16));
      for (int i = 0; i < 9; i++) run(4'b1010);
      rst = 1; tick(); rst = 0;
      run(4'b1000, 12'h030);
      irq = 1; int_en = 1; vec = 12'h200;
      run(4'b0000); run(4'b0000);
      repeat (3) run(4'b0000);
      irq = 0; run(4'b1011);
      stall = 1; repeat (3) run(4'b1000, 12'h123);
      stall = 0; run(4'b1000, 12'h123);
      irq = 1; run(4'b1001, 12'h400); run(4'b1001, 12'h400);
      irq = 0; run(4'b1001, 12'h400); run(4'b1010); run(4'b1011);
      for (int i = 0; i < 3000; i++) begin
         rst    = $urandom_range(0, 199) == 0;
         stall  = $urandom_range(0, 9) == 0;
         irq    = $urandom_range(0, 7) == 0;
         int_en = $urandom_range(0, 3) != 0;
         zero   = 1'($urandom);
         carry  = 1'($urandom);
         vec    = 12'($urandom);
         run(4'($urandom), 12'($urandom), 8'($urandom));
      end
      rst = 0; stall = 0; irq = 0;
      for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending %0d expected 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
